// File: rtl/bram_sweep_ctrl.sv
// Sweep controller for a simple dual-port block RAM: FILL writes pat(a) = seed + a to
// every location, CHECK reads it back and counts mismatches; idle cycles bypass a user port.
module bram_sweep_ctrl #(
    parameter int WIDTH  = 18,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int ERR_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [WIDTH-1:0]  seed_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    input  logic [ADDR_W-1:0] user_raddr_i,
    input  logic [ADDR_W-1:0] user_waddr_i,
    input  logic [WIDTH-1:0]  user_din_i,
    input  logic              user_we_i,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [WIDTH-1:0]  mem_din_o,
    output logic              mem_we_o,
    input  logic [WIDTH-1:0]  mem_dout_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_CHECK,
        ST_DRAIN
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  seed_q, seed_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              seen_q, seen_d;
    logic              pass_q, pass_d;
    logic              aborted_q, aborted_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  pat_addr;
    logic [WIDTH-1:0]  pat_paddr;
    logic              mismatch;

    assign pat_addr  = seed_q + WIDTH'(addr_q);
    assign pat_paddr = seed_q + WIDTH'(paddr_q);

    // A pending compare is dropped when abort is sampled in the same cycle.
    assign mismatch  = vld_q && !abort_i && (mem_dout_i != pat_paddr);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        vld_d       = 1'b0;
        paddr_d     = paddr_q;
        err_d       = err_q;
        first_d     = first_q;
        seen_d      = seen_q;
        pass_d      = pass_q;
        aborted_d   = aborted_q;
        done_d      = 1'b0;
        mem_raddr_o = addr_q;
        mem_waddr_o = addr_q;
        mem_din_o   = pat_addr;
        mem_we_o    = 1'b0;

        // seen_q keeps pass correct once the counter has saturated.
        if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + 1'b1;
            end
            if (!seen_q) begin
                first_d = paddr_q;
            end
            seen_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                mem_raddr_o = user_raddr_i;
                mem_waddr_o = user_waddr_i;
                mem_din_o   = user_din_i;
                mem_we_o    = user_we_i;
                if (start_i && !abort_i) begin
                    state_d   = mode_i ? ST_CHECK : ST_FILL;
                    addr_d    = '0;
                    seed_d    = seed_i;
                    err_d     = '0;
                    first_d   = '0;
                    seen_d    = 1'b0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            ST_FILL: begin
                mem_we_o = 1'b1;
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    vld_d   = 1'b1;
                    paddr_d = addr_q;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (abort_i) begin
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    pass_d = !(seen_q || mismatch);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            seed_q    <= '0;
            vld_q     <= 1'b0;
            paddr_q   <= '0;
            err_q     <= '0;
            first_q   <= '0;
            seen_q    <= 1'b0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            seed_q    <= seed_d;
            vld_q     <= vld_d;
            paddr_q   <= paddr_d;
            err_q     <= err_d;
            first_q   <= first_d;
            seen_q    <= seen_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_bram_sweep_ctrl.sv
// Bench for bram_sweep_ctrl: a sweep-level model predicts every output each cycle,
// and a small ERR_W=2 instance covers counter saturation and non-power-of-two depth.
`timescale 1ns/1ps
module tb_bram_sweep_ctrl;

    localparam int WIDTH    = 18;
    localparam int DEPTH    = 4096;
    localparam int ADDR_W   = 12;
    localparam int ERR_W    = 16;
    localparam int S_DEPTH  = 20;
    localparam int S_ADDR_W = 5;
    localparam int S_ERR_W  = 2;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic [WIDTH-1:0]  seed = '0;
    logic              busy, done, aborted, pass;
    logic [ERR_W-1:0]  errCount;
    logic [ADDR_W-1:0] firstErrAddr;
    logic [ADDR_W-1:0] userRaddr = '0, userWaddr = '0;
    logic [WIDTH-1:0]  userDin = '0;
    logic              userWe = 1'b0;
    logic [ADDR_W-1:0] memRaddr, memWaddr;
    logic [WIDTH-1:0]  memDin, memDout;
    logic              memWe;
    logic [WIDTH-1:0]  ram [0:DEPTH-1];

    logic                sStart = 1'b0, sMode = 1'b0;
    logic [WIDTH-1:0]    sSeed = '0;
    logic                sBusy, sDone, sAborted, sPass;
    logic [S_ERR_W-1:0]  sErr;
    logic [S_ADDR_W-1:0] sFirst, sMemRaddr, sMemWaddr;
    logic [WIDTH-1:0]    sMemDin, sMemDout;
    logic                sMemWe;
    logic [WIDTH-1:0]    sram [0:31];

    int total = 0;
    int bad   = 0;

    // Model state: sweep-level view of what the controller must be doing.
    logic [WIDTH-1:0]  expMem [0:DEPTH-1];
    bit                mActive = 0, mMode = 0, mDone = 0, mPass = 0, mAborted = 0;
    int                mK = 0, mErr = 0;
    logic [ADDR_W-1:0] mFirst = '0;
    logic [WIDTH-1:0]  mSeed = '0;

    always #5 clk = ~clk;

    bram_sweep_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .mode_i(mode), .seed_i(seed),
        .abort_i(abort), .busy_o(busy), .done_o(done), .aborted_o(aborted), .pass_o(pass),
        .err_count_o(errCount), .first_err_addr_o(firstErrAddr),
        .user_raddr_i(userRaddr), .user_waddr_i(userWaddr), .user_din_i(userDin),
        .user_we_i(userWe), .mem_raddr_o(memRaddr), .mem_waddr_o(memWaddr),
        .mem_din_o(memDin), .mem_we_o(memWe), .mem_dout_i(memDout)
    );

    bram_sweep_ctrl #(.WIDTH(WIDTH), .DEPTH(S_DEPTH), .ADDR_W(S_ADDR_W), .ERR_W(S_ERR_W)) dutSmall (
        .clk_i(clk), .rst_ni(rstN), .start_i(sStart), .mode_i(sMode), .seed_i(sSeed),
        .abort_i(1'b0), .busy_o(sBusy), .done_o(sDone), .aborted_o(sAborted), .pass_o(sPass),
        .err_count_o(sErr), .first_err_addr_o(sFirst),
        .user_raddr_i('0), .user_waddr_i('0), .user_din_i('0),
        .user_we_i(1'b0), .mem_raddr_o(sMemRaddr), .mem_waddr_o(sMemWaddr),
        .mem_din_o(sMemDin), .mem_we_o(sMemWe), .mem_dout_i(sMemDout)
    );

    function automatic logic [WIDTH-1:0] initVal(input int i);
        return WIDTH'(i * 37 + 'h15555);
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = initVal(i);
        forever begin
            @(posedge clk);
            memDout <= ram[memRaddr];
            if (memWe) ram[memWaddr] <= memDin;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) sram[i] = WIDTH'('h30000 + i);
        forever begin
            @(posedge clk);
            sMemDout <= sram[sMemRaddr];
            if (sMemWe) sram[sMemWaddr] <= sMemDin;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle k of a sweep is the k-th cycle after start is sampled; FILL writes address k-1
    // at the edge ending cycle k, CHECK compares address k-2 there.
    task automatic modelStep();
        logic [WIDTH-1:0] want;
        if (!rstN) begin
            mActive = 0; mDone = 0; mPass = 0; mAborted = 0; mErr = 0; mFirst = '0;
            return;
        end
        mDone = 0;
        if (!mActive) begin
            if (userWe) expMem[userWaddr] = userDin;
            if (start && !abort) begin
                mActive = 1; mMode = mode; mSeed = seed; mK = 1;
                mErr = 0; mFirst = '0; mPass = 0; mAborted = 0;
            end
        end else if (abort) begin
            if (!mMode) expMem[mK-1] = WIDTH'(mSeed + WIDTH'(mK - 1));
            mActive = 0; mDone = 1; mAborted = 1; mPass = 0;
        end else begin
            if (!mMode) begin
                expMem[mK-1] = WIDTH'(mSeed + WIDTH'(mK - 1));
            end else if (mK >= 2) begin
                want = mSeed + WIDTH'(mK - 2);
                if (expMem[mK-2] != want) begin
                    if (mErr == 0) mFirst = ADDR_W'(mK - 2);
                    if (mErr < 2**ERR_W - 1) mErr++;
                end
            end
            if (mK == (mMode ? DEPTH + 1 : DEPTH)) begin
                mActive = 0; mDone = 1; mPass = mMode ? (mErr == 0) : 1'b1;
            end else begin
                mK++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) expMem[i] = initVal(i);
        forever begin
            @(posedge clk or negedge rstN);
            modelStep();
        end
    end

    task automatic compareCycle();
        logic [WIDTH-1:0] pat;
        checkOutput("busy", 32'(busy), 32'(mActive));
        checkOutput("done", 32'(done), 32'(mDone));
        checkOutput("pass", 32'(pass), 32'(mPass));
        checkOutput("aborted", 32'(aborted), 32'(mAborted));
        checkOutput("errCount", 32'(errCount), 32'(mErr));
        checkOutput("firstErrAddr", 32'(firstErrAddr), 32'(mFirst));
        if (!mActive) begin
            checkOutput("bypassWe", 32'(memWe), 32'(userWe));
            checkOutput("bypassWaddr", 32'(memWaddr), 32'(userWaddr));
            checkOutput("bypassRaddr", 32'(memRaddr), 32'(userRaddr));
            checkOutput("bypassDin", 32'(memDin), 32'(userDin));
        end else if (!mMode) begin
            pat = mSeed + WIDTH'(mK - 1);
            checkOutput("fillWe", 32'(memWe), 32'd1);
            checkOutput("fillAddr", 32'(memWaddr), 32'(mK - 1));
            checkOutput("fillData", 32'(memDin), 32'(pat));
        end else if (mK <= DEPTH) begin
            checkOutput("checkWe", 32'(memWe), 32'd0);
            checkOutput("checkAddr", 32'(memRaddr), 32'(mK - 1));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compareCycle();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        userWe    = mActive ? 1'($urandom) : 1'b0;
        userRaddr = ADDR_W'($urandom);
        userWaddr = ADDR_W'($urandom);
        userDin   = WIDTH'($urandom);
    endtask

    task automatic applyStimulus(input logic m, input logic [WIDTH-1:0] s);
        mode  = m;
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 1'($urandom);
        seed  = WIDTH'($urandom);
    endtask

    task automatic waitDone(input string name, output int n);
        n = 1;
        while (done !== 1'b1 && n < 3 * DEPTH) begin
            tick();
            n++;
        end
        if (done !== 1'b1) checkOutput({name, "Timeout"}, 32'd0, 32'd1);
    endtask

    task automatic runSmall();
        int n;
        sMode = 1'b0; sSeed = '0; sStart = 1'b1; tick(); sStart = 1'b0;
        for (n = 1; sDone !== 1'b1 && n < 100; n++) tick();
        checkOutput("smallFillCycle", 32'(n), 32'd21);
        checkOutput("smallFillPass", 32'(sPass), 32'd1);
        checkOutput("smallLastWrite", 32'(sram[19]), 32'd19);
        checkOutput("smallNoOverrun", 32'(sram[20]), 32'h30014);
        tick();
        sMode = 1'b1; sSeed = WIDTH'(1); sStart = 1'b1; tick(); sStart = 1'b0;
        for (n = 1; sDone !== 1'b1 && n < 100; n++) tick();
        checkOutput("smallCheckCycle", 32'(n), 32'd22);
        checkOutput("smallSatErr", 32'(sErr), 32'd3);
        checkOutput("smallSatFirst", 32'(sFirst), 32'd0);
        checkOutput("smallSatPass", 32'(sPass), 32'd0);
        tick();
        sMode = 1'b1; sSeed = '0; sStart = 1'b1; tick(); sStart = 1'b0;
        for (n = 1; sDone !== 1'b1 && n < 100; n++) tick();
        checkOutput("smallCleanErr", 32'(sErr), 32'd0);
        checkOutput("smallCleanPass", 32'(sPass), 32'd1);
        checkOutput("smallCleanAborted", 32'(sAborted), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first (with hand-computed literals), then random sweeps.
    initial begin
        int n;
        logic [WIDTH-1:0] s1, s2;
        bit doAbort;
        int abCyc;

        repeat (3) tick();
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetErr", 32'(errCount), 32'd0);
        rstN = 1'b1;
        tick(); tick();

        runSmall();
        tick();

        applyStimulus(1'b0, WIDTH'('h000AA));
        waitDone("fillAA", n);
        checkOutput("fillAADoneCycle", 32'(n), 32'd4097);
        checkOutput("fillAAPass", 32'(pass), 32'd1);
        tick();

        applyStimulus(1'b1, WIDTH'('h000AA));
        waitDone("checkAA", n);
        checkOutput("checkAADoneCycle", 32'(n), 32'd4098);
        checkOutput("checkAAErr", 32'(errCount), 32'd0);
        checkOutput("checkAAPass", 32'(pass), 32'd1);
        checkOutput("checkAAAborted", 32'(aborted), 32'd0);
        tick();

        userWe = 1'b1; userWaddr = ADDR_W'(5); userDin = WIDTH'('h3FFFF); tick();
        userWe = 1'b1; userWaddr = ADDR_W'(4095); userDin = '0; tick();
        applyStimulus(1'b1, WIDTH'('h000AA));
        waitDone("checkCorrupt", n);
        checkOutput("corruptErr", 32'(errCount), 32'd2);
        checkOutput("corruptFirst", 32'(firstErrAddr), 32'd5);
        checkOutput("corruptPass", 32'(pass), 32'd0);
        tick();

        applyStimulus(1'b1, WIDTH'('h00155));
        for (int i = 1; i < 100; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortDone", 32'(done), 32'd1);
        checkOutput("abortFlag", 32'(aborted), 32'd1);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortPass", 32'(pass), 32'd0);
        checkOutput("abortErr", 32'(errCount), 32'd98);
        tick();

        s1 = WIDTH'($urandom);
        applyStimulus(1'b0, s1);
        n = 1;
        while (done !== 1'b1 && n < 3 * DEPTH) begin
            start = ($urandom_range(0, 63) == 0);
            mode  = 1'b1;
            tick();
            n++;
        end
        start = 1'b0;
        checkOutput("fillStartIgnoredCycle", 32'(n), 32'd4097);
        tick();

        start = 1'b1; abort = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0; abort = 1'b0;
        checkOutput("startAbortBusy", 32'(busy), 32'd0);
        checkOutput("startAbortDone", 32'(done), 32'd0);
        repeat (3) tick();
        checkOutput("startAbortStillIdle", 32'(busy), 32'd0);

        s2 = s1 + WIDTH'(1 + $urandom_range(0, 1000));
        applyStimulus(1'b0, s2);
        for (int i = 1; i < 1001; i++) tick();
        rstN = 1'b0; userWe = 1'b0;
        tick(); tick();
        rstN = 1'b1;
        tick();
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetDone", 32'(done), 32'd0);
        checkOutput("midResetPass", 32'(pass), 32'd0);
        checkOutput("midResetAborted", 32'(aborted), 32'd0);
        checkOutput("midResetErr", 32'(errCount), 32'd0);
        applyStimulus(1'b1, s2);
        waitDone("checkAfterReset", n);
        checkOutput("afterResetErr", 32'(errCount), 32'd3096);
        checkOutput("afterResetFirst", 32'(firstErrAddr), 32'd1000);

        for (int it = 0; it < 3; it++) begin
            tick();
            repeat ($urandom_range(1, 4)) begin
                userWe = 1'b1; userWaddr = ADDR_W'($urandom); userDin = WIDTH'($urandom);
                tick();
            end
            doAbort = 1'($urandom);
            abCyc   = $urandom_range(2, DEPTH);
            applyStimulus(1'($urandom), WIDTH'($urandom));
            n = 1;
            while (done !== 1'b1 && n < 3 * DEPTH) begin
                abort = doAbort && (n == abCyc);
                tick();
                n++;
            end
            abort = 1'b0;
            if (done !== 1'b1) checkOutput("randomSweepTimeout", 32'd0, 32'd1);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_sweep_ctrl.md
# bram_sweep_ctrl

Sweep controller for the 18-bit × 4096-entry simple dual-port block RAM used in the memory-reinit designs. It runs two kinds of full-depth sweep:
- **FILL:** writes an address-derived pattern to every location.
- **CHECK:** reads every location back and compares it against the same pattern, counting mismatches and capturing the first failing address.

When the controller is idle, a user port passes straight through to the RAM. This lets reinitialised contents be checked in-fabric.

## Interface
Parameters:
- WIDTH, 18, RAM data width
- DEPTH, 4096, number of locations swept (not required to be a power of two)
- ADDR_W, 12, address width; DEPTH ≤ 2^ADDR_W
- ERR_W, 16, error counter width (saturating)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  sampled in IDLE only; begins a sweep
- mode  in  1  0 = FILL, 1 = CHECK; latched with start
- seed  in  WIDTH  pattern seed; latched with start
- abort  in  1  stops an active sweep
- busy  out  1  high while sweeping (FILL, CHECK or DRAIN)
- done  out  1  one-cycle pulse when a sweep ends, normally or by abort
- aborted  out  1  valid with done; held until the next start
- pass  out  1  valid with done; held until the next start
- err_count  out  ERR_W  mismatch count; held until the next start
- first_err_addr  out  ADDR_W  address of the first mismatch; held
- user_raddr, user_waddr  in  ADDR_W  bypass addresses
- user_din  in  WIDTH  bypass write data
- user_we  in  1  bypass write enable
- mem_raddr, mem_waddr  out  ADDR_W  to RAM
- mem_din  out  WIDTH  to RAM
- mem_we  out  1  RAM write enable
- mem_dout  in  WIDTH  RAM read data, 1-cycle read latency

## Operation
- Pattern definition: pat(a) = (seed_q + zero-extended a) mod 2^WIDTH, where seed_q is the seed latched at start.
- States:
  - IDLE → FILL or CHECK when start=1 and abort=0; mode selects which. On entry: addr ← 0, err_count ← 0, first_err_addr ← 0, pass ← 0, aborted ← 0.
  - FILL: mem_we=1, mem_waddr=addr, mem_din=pat(addr). addr increments each cycle. After addr = DEPTH-1 → IDLE with done=1 and pass=1.
  - CHECK: mem_raddr=addr, mem_we=0. Pipeline register records (vld, addr) for each read issued. After addr = DEPTH-1 → DRAIN.
  - DRAIN: the last compare occurs here, then → IDLE with done=1 and pass = (final err_count == 0).
- Compare rule: in the cycle after a read is issued (vld=1), mem_dout is compared with pat(pipelined addr).
  - On mismatch, err_count increments and saturates at 2^ERR_W-1.
  - If this is the first mismatch of the sweep, first_err_addr ← pipelined addr.
  - A flag tracks whether any error occurred, so pass remains correct after the counter saturates.
- Bypass: in IDLE, the mem_* ports combinationally equal the user_* ports, with mem_we = user_we. When busy, user inputs are ignored and user writes are dropped.
- Abort:
  - Sampled in FILL, CHECK or DRAIN → IDLE next edge with done=1, aborted=1, pass=0.
  - Counters keep the values accumulated so far. A compare already pending in the pipeline is discarded.
- Start while busy is ignored. Start and abort high in the same IDLE cycle: abort wins and no sweep begins.
- Reset (asynchronous, active-low) at any time:
  - state → IDLE, pipeline vld=0.
  - Outputs reset to busy=0, done=0, aborted=0, pass=0, err_count=0, first_err_addr=0. mem_we takes the bypass value.
  - Any partial fill is left as-is in the RAM.

## Timing
- Start sampled at edge E0. busy=1 from E0 onward.
- FILL: writes occur on edges E1..E_DEPTH. busy falls and done pulses for the cycle after E_DEPTH.
  - Total: DEPTH cycles busy, with done in cycle DEPTH+1 relative to start.
- CHECK: reads are issued in cycles 1..DEPTH. Compares happen in cycles 2..DEPTH+1; cycle DEPTH+1 is DRAIN. done pulses in cycle DEPTH+2.
  - Total: DEPTH+1 cycles busy.
- done, pass, aborted, err_count and first_err_addr are registered. pass and aborted change only at sweep end or at start.
- Abort sampled at edge Ea: busy=0 and done=1 in the cycle after Ea.

## Test plan
- FILL with seed=0x00AA, then CHECK with seed=0x00AA → err_count=0, pass=1, aborted=0. done appears at cycle 4097 (FILL) and cycle 4098 (CHECK).
- FILL with seed=0x00AA; in IDLE, user write addr 5 ← 0x3FFFF and addr 4095 ← 0; then CHECK → err_count=2, first_err_addr=5, pass=0.
- ERR_W=2: FILL with seed=0, then CHECK with seed=1 → err_count=3 (saturated), first_err_addr=0, pass=0.
- CHECK with abort asserted at cycle 100 → done and aborted on the next cycle, busy=0, and err_count reflects only the compares completed.
- start pulsed during an active FILL → ignored, done still at cycle 4097. start+abort together in IDLE → no busy, no done.
- reset pulled low mid-FILL at addr 1000, then released → IDLE with all outputs 0. A following CHECK reports err_count=3096 when the RAM's prior contents mismatch everywhere.
